mem_access_sequencer: RTL

Sequences memory read/write transactions between the Mini SRC control unit, the memory and the memory data register (MDR).
- Accepts a read or write request and drives the memory strobes.
- Waits on the memory ready handshake.
- Drives the MDR source-select and load-enable so read data is captured in the MDR.
- Signals completion to the control unit with a single-cycle done pulse.

---
 rtl/mem_access_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// Memory read/write sequencer between the Mini SRC control unit, memory and the MDR.
// Optional wait-state timeout is compiled in with `define MEM_TIMEOUT_EN.
module mem_access_sequencer #(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mdr_read,
    output logic              mdr_load,
    output logic              err
);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdLatch,
        StWrWait,
        StDone
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   timeout;
    logic   to_err;

    assign accept = (state == StIdle) && (rd_req || wr_req);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] wait_cnt;

    assign timeout = (wait_cnt == CntW'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside the wait states, so it is clear on every entry.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wait_cnt <= '0;
        end else if (state == StRdWait || state == StWrWait) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (to_err) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // Ready takes priority over timeout in the wait states.
    always_comb begin
        state_nxt = state;
        to_err    = 1'b0;
        unique case (state)
            StIdle: begin
                if (rd_req) begin
                    state_nxt = StRdWait;
                end else if (wr_req) begin
                    state_nxt = StWrWait;
                end
            end
            StRdWait: begin
                if (mem_ready) begin
                    state_nxt = StRdLatch;
                end else if (timeout) begin
                    state_nxt = StDone;
                    to_err    = 1'b1;
                end
            end
            StRdLatch: state_nxt = StDone;
            StWrWait: begin
                if (mem_ready) begin
                    state_nxt = StDone;
                end else if (timeout) begin
                    state_nxt = StDone;
                    to_err    = 1'b1;
                end
            end
            StDone:  state_nxt = StIdle;
            default: state_nxt = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mdr_read  <= 1'b0;
            mdr_load  <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != StIdle);
            done      <= (state_nxt == StDone);
            mem_read  <= (state_nxt == StRdWait) || (state_nxt == StRdLatch);
            mem_write <= (state_nxt == StWrWait);
            mdr_read  <= (state_nxt == StRdLatch);
            mdr_load  <= (state_nxt == StRdLatch);
            if (accept) begin
                mem_addr <= addr;
            end
        end
    end

endmodule
